// File: rtl/handshake_cdc_scheduler.sv
// Source-domain side of a shared 4-phase req/ack CDC channel: round-robin pick among
// requesters, latch the winner's word, then sequence req/ack with an optional ack timeout.
module handshake_cdc_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            in_clk,
    input  logic                            in_rst,
    input  logic [NUM_REQ-1:0]              in_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_REQ-1:0]              out_done,
    output logic                            out_xfer_req,
    output logic [DATA_WIDTH-1:0]           out_xfer_data,
    input  logic                            in_xfer_ack,
    output logic                            out_busy,
    output logic                            out_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]            state;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      idx;
    logic                  grant_q;
    logic [CNT_W-1:0]      cnt;

    logic [NUM_REQ-1:0]    hi_mask;
    logic [NUM_REQ-1:0]    req_hi;
    logic [NUM_REQ-1:0]    pick_src;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      ptr_next;
    logic [DATA_WIDTH-1:0] win_data;
    logic [NUM_REQ-1:0]    done_vec;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  cnt_hit;

    // Requests at or above ptr take priority; otherwise wrap to the lowest set bit.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hi_mask[k] = (k >= int'(ptr));
        end
        req_hi   = in_req & hi_mask;
        pick_src = (req_hi != '0) ? req_hi : in_req;
        win_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pick_src[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        win_data = in_data[int'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
        done_vec = '0;
        done_vec[idx] = 1'b1;
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        cnt_hit = TO_EN && (cnt_inc == CNT_LIMIT);
    end

    assign out_busy = (state != ST_IDLE);

    // The word is latched one cycle before req rises so data is settled ahead of the request.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            idx           <= '0;
            grant_q       <= 1'b0;
            cnt           <= '0;
            out_xfer_req  <= 1'b0;
            out_xfer_data <= '0;
            out_done      <= '0;
            out_timeout   <= 1'b0;
        end else begin
            out_done    <= '0;
            out_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (grant_q) begin
                        grant_q      <= 1'b0;
                        out_xfer_req <= 1'b1;
                        state        <= ST_REQ;
                    end else if (in_req != '0) begin
                        grant_q       <= 1'b1;
                        idx           <= win_idx;
                        out_xfer_data <= win_data;
                        ptr           <= ptr_next;
                    end
                end
                ST_REQ: begin
                    if (in_xfer_ack) begin
                        out_done     <= done_vec;
                        out_xfer_req <= 1'b0;
                        state        <= ST_RELEASE;
                        cnt          <= '0;
                    end else if (cnt_hit) begin
                        out_timeout  <= 1'b1;
                        out_xfer_req <= 1'b0;
                        state        <= ST_RELEASE;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    // Never leave while ack is high; a timeout here only flags and rearms.
                    if (!in_xfer_ack) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt_hit) begin
                        out_timeout <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    out_xfer_req <= 1'b0;
                    grant_q      <= 1'b0;
                    cnt          <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_cdc_scheduler.sv
// Bench for handshake_cdc_scheduler: random payloads and ack timing against a round-robin
// reference model; a TIMEOUT_CYCLES=16 instance plus a TIMEOUT_CYCLES=0 instance.
module tb_handshake_cdc_scheduler;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic [3:0]  in_req = '0;
    logic [31:0] in_data = '0;
    logic        in_xfer_ack = 1'b0;
    logic [3:0]  out_done;
    logic        out_xfer_req;
    logic [7:0]  out_xfer_data;
    logic        out_busy;
    logic        out_timeout;

    logic [3:0]  z_req = '0;
    logic [31:0] z_data = '0;
    logic        z_ack = 1'b0;
    logic [3:0]  z_done;
    logic        z_xfer_req;
    logic [7:0]  z_xfer_data;
    logic        z_busy;
    logic        z_timeout;

    int vectors = 0;
    int miscompares = 0;
    int m_ptr = 0;
    logic [7:0] m_data [4];
    logic [9:0] exp_q [$];
    int done_pulses = 0;
    int z_done_pulses = 0;
    int z_to_pulses = 0;
    int multi_hot = 0;

    handshake_cdc_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_req(in_req), .in_data(in_data),
        .out_done(out_done), .out_xfer_req(out_xfer_req), .out_xfer_data(out_xfer_data),
        .in_xfer_ack(in_xfer_ack), .out_busy(out_busy), .out_timeout(out_timeout)
    );

    handshake_cdc_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(0)) dut0 (
        .in_clk(in_clk), .in_rst(in_rst), .in_req(z_req), .in_data(z_data),
        .out_done(z_done), .out_xfer_req(z_xfer_req), .out_xfer_data(z_xfer_data),
        .in_xfer_ack(z_ack), .out_busy(z_busy), .out_timeout(z_timeout)
    );

    // clock / reset
    always #5 in_clk = ~in_clk;

    always @(negedge in_clk) begin
        if (!in_rst) begin
            done_pulses   += $countones(out_done);
            z_done_pulses += $countones(z_done);
            z_to_pulses   += int'(z_timeout);
            if ($countones(out_done) > 1 || $countones(z_done) > 1) multi_hot++;
        end
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        in_req = '0;
        in_xfer_ack = 1'b0;
        tick();
        tick();
        in_rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic set_data();
        in_data = {m_data[3], m_data[2], m_data[1], m_data[0]};
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) m_data[i] = 8'($urandom_range(0, 255));
        set_data();
    endtask

    // reference arbiter: first asserted requester scanning upward from the pointer
    function automatic int model_pick(input logic [3:0] mask, input int p);
        for (int k = 0; k < 4; k++) begin
            if (mask[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int model_grant(input logic [3:0] mask);
        int w;
        w = model_pick(mask, m_ptr);
        if (w >= 0) m_ptr = (w + 1) % 4;
        return w;
    endfunction

    // receiver driver: one 4-phase exchange on the timed instance
    task automatic serve(input int ack_dly, input int rel_dly, input bit drop,
                         output int req_lat, output logic [7:0] d_req, output logic [7:0] d_done,
                         output logic [3:0] done_obs, output bit hung);
        int n;
        hung = 1'b0; req_lat = 0; d_req = '0; d_done = '0; done_obs = '0;
        n = 0;
        while (!out_xfer_req && n < 20) begin tick(); n++; end
        req_lat = n;
        if (!out_xfer_req) begin hung = 1'b1; return; end
        d_req = out_xfer_data;
        repeat (ack_dly) tick();
        in_xfer_ack = 1'b1;
        n = 0;
        while (out_done == '0 && n < 20) begin tick(); n++; end
        if (out_done == '0) begin hung = 1'b1; in_xfer_ack = 1'b0; return; end
        done_obs = out_done;
        d_done = out_xfer_data;
        if (drop) in_req = in_req & ~out_done;
        repeat (rel_dly) tick();
        in_xfer_ack = 1'b0;
        n = 0;
        while (out_busy && n < 20) begin tick(); n++; end
        if (out_busy) hung = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (out_xfer_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", out_xfer_req); end
        vectors++; if (out_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", out_busy); end
        vectors++; if (out_done !== 4'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0000", out_done); end
        vectors++; if (out_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", out_timeout); end
        vectors++; if (out_xfer_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", out_xfer_data); end
        vectors++; if (z_busy !== 1'b0 || z_xfer_req !== 1'b0) begin miscompares++; $display("FAIL reset_dut0: got busy=%b req=%b want 0 0", z_busy, z_xfer_req); end
    endtask

    task automatic test_single();
        int lat, p0, w; logic [7:0] dq, dd; logic [3:0] dn; bit hung;
        rand_data();
        m_data[0] = 8'hA5;
        set_data();
        in_req = 4'b0001;
        w = model_grant(in_req);
        p0 = done_pulses;
        serve(3, 3, 1'b1, lat, dq, dd, dn, hung);
        vectors++; if (hung) begin miscompares++; $display("FAIL single_hang: got hang want progress"); end
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL single_latency: got %0d want 2", lat); end
        vectors++; if (dq !== 8'hA5 || dd !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h/%h want a5", dq, dd); end
        vectors++; if (dn !== 4'(1) << w) begin miscompares++; $display("FAIL single_done: got %b want %b", dn, 4'(1) << w); end
        vectors++; if (done_pulses - p0 != 1) begin miscompares++; $display("FAIL single_pulses: got %0d want 1", done_pulses - p0); end
        vectors++; if (out_busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got busy=%b want 0", out_busy); end
    endtask

    task automatic test_fairness();
        int lat, p0, w; logic [7:0] dq, dd; logic [3:0] dn; bit hung; logic [9:0] e;
        do_reset();
        p0 = done_pulses;
        for (int pass = 0; pass < 2; pass++) begin
            rand_data();
            in_req = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                w = model_grant(in_req);
                exp_q.push_back({2'(w), m_data[w]});
                serve($urandom_range(0, 6), $urandom_range(0, 6), 1'b1, lat, dq, dd, dn, hung);
                e = exp_q.pop_front();
                vectors++;
                if (hung || dn !== 4'(1) << e[9:8] || dd !== e[7:0]) begin
                    miscompares++;
                    $display("FAIL fair_p%0d_%0d: got done=%b data=%h want done=%b data=%h", pass, i, dn, dd, 4'(1) << e[9:8], e[7:0]);
                end
            end
        end
        vectors++; if (done_pulses - p0 != 8) begin miscompares++; $display("FAIL fair_pulses: got %0d want 8", done_pulses - p0); end
    endtask

    task automatic test_ptr_wrap();
        int lat, w; logic [7:0] dq, dd; logic [3:0] dn; bit hung;
        rand_data();
        in_req = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            w = model_grant(in_req);
            serve($urandom_range(0, 4), $urandom_range(0, 4), 1'b0, lat, dq, dd, dn, hung);
            if (i == 1) in_req = '0;
            vectors++;
            if (hung || dn !== 4'(1) << w || dd !== m_data[w]) begin
                miscompares++;
                $display("FAIL wrap_%0d: got done=%b data=%h want done=%b data=%h", i, dn, dd, 4'(1) << w, m_data[w]);
            end
        end
    endtask

    task automatic test_random_rr();
        int lat, w; logic [7:0] dq, dd; logic [3:0] dn; bit hung;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            in_req = 4'($urandom_range(1, 15));
            w = model_grant(in_req);
            serve($urandom_range(0, 6), $urandom_range(0, 6), 1'b0, lat, dq, dd, dn, hung);
            if (i == 9) in_req = '0;
            vectors++;
            if (hung || dn !== 4'(1) << w || dd !== m_data[w] || dq !== m_data[w]) begin
                miscompares++;
                $display("FAIL rand_%0d: got done=%b data=%h want done=%b data=%h", i, dn, dd, 4'(1) << w, m_data[w]);
            end
        end
    endtask

    task automatic test_drop_mid();
        int lat, n, w; logic [7:0] dq, dd, orig; logic [3:0] dn; bit hung;
        rand_data();
        orig = m_data[1];
        in_req = 4'b0010;
        w = model_grant(in_req);
        n = 0;
        while (!out_xfer_req && n < 10) begin tick(); n++; end
        in_req = '0;
        m_data[1] = ~orig;
        set_data();
        serve(2, 2, 1'b0, lat, dq, dd, dn, hung);
        vectors++;
        if (hung || dn !== 4'(1) << w || dd !== orig) begin
            miscompares++;
            $display("FAIL drop_mid: got done=%b data=%h want done=%b data=%h", dn, dd, 4'(1) << w, orig);
        end
    endtask

    task automatic test_timeout();
        int lat, n, p0, w, to_cnt, first_at; logic [7:0] dq, dd; logic [3:0] dn; bit hung, req_seen, idle_seen;
        rand_data();
        in_req = 4'b0100;
        w = model_grant(in_req);
        p0 = done_pulses;
        n = 0;
        while (!out_xfer_req && n < 10) begin tick(); n++; end
        n = 0;
        while (out_xfer_req && n < 40) begin tick(); n++; end
        vectors++; if (n != 16) begin miscompares++; $display("FAIL to_req_cycles: got %0d want 16", n); end
        vectors++; if (out_timeout !== 1'b1 || out_done !== 4'b0) begin miscompares++; $display("FAIL to_pulse: got to=%b done=%b want 1 0000", out_timeout, out_done); end
        tick();
        vectors++; if (out_timeout !== 1'b0 || out_busy !== 1'b0) begin miscompares++; $display("FAIL to_idle: got to=%b busy=%b want 0 0", out_timeout, out_busy); end
        w = model_grant(in_req);
        serve(2, 2, 1'b1, lat, dq, dd, dn, hung);
        vectors++; if (hung || dn !== 4'(1) << w || dd !== m_data[w]) begin miscompares++; $display("FAIL to_retry: got done=%b data=%h want done=%b data=%h", dn, dd, 4'(1) << w, m_data[w]); end
        vectors++; if (done_pulses - p0 != 1) begin miscompares++; $display("FAIL to_pulses: got %0d want 1", done_pulses - p0); end

        // ack stuck high after acceptance: periodic timeout, channel held
        in_req = 4'b0001;
        w = model_grant(in_req);
        n = 0;
        while (!out_xfer_req && n < 10) begin tick(); n++; end
        in_xfer_ack = 1'b1;
        n = 0;
        while (out_done == '0 && n < 10) begin tick(); n++; end
        vectors++; if (out_done !== 4'(1) << w) begin miscompares++; $display("FAIL stuck_done: got %b want %b", out_done, 4'(1) << w); end
        in_req = 4'b0010;
        to_cnt = 0; first_at = 0; req_seen = 1'b0; idle_seen = 1'b0;
        for (int t = 1; t <= 48; t++) begin
            tick();
            if (out_timeout) begin
                to_cnt++;
                if (first_at == 0) first_at = t;
            end
            if (out_xfer_req) req_seen = 1'b1;
            if (!out_busy) idle_seen = 1'b1;
        end
        vectors++; if (to_cnt != 3 || first_at != 16) begin miscompares++; $display("FAIL stuck_timeouts: got %0d first@%0d want 3 first@16", to_cnt, first_at); end
        vectors++; if (req_seen || idle_seen) begin miscompares++; $display("FAIL stuck_reuse: got req=%b idle=%b want 0 0", req_seen, idle_seen); end
        in_xfer_ack = 1'b0;
        n = 0;
        while (out_busy && n < 10) begin tick(); n++; end
        w = model_grant(in_req);
        serve(1, 1, 1'b1, lat, dq, dd, dn, hung);
        vectors++; if (hung || dn !== 4'(1) << w) begin miscompares++; $display("FAIL stuck_next: got done=%b want %b", dn, 4'(1) << w); end
    endtask

    task automatic test_reset_mid();
        int lat, n, p0, w; logic [7:0] dq, dd; logic [3:0] dn; bit hung;
        rand_data();
        in_req = 4'b0010;
        w = model_grant(in_req);
        n = 0;
        while (!out_xfer_req && n < 10) begin tick(); n++; end
        p0 = done_pulses;
        in_rst = 1'b1;
        in_xfer_ack = 1'b1;
        tick();
        vectors++; if (out_xfer_req !== 1'b0 || out_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_req_busy: got %b %b want 0 0", out_xfer_req, out_busy); end
        vectors++; if (out_done !== 4'b0 || out_timeout !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b %b want 0000 0", out_done, out_timeout); end
        in_xfer_ack = 1'b0;
        in_req = 4'b0101;
        m_ptr = 0;
        in_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w = model_grant(in_req);
            serve($urandom_range(0, 5), $urandom_range(0, 5), 1'b1, lat, dq, dd, dn, hung);
            vectors++;
            if (hung || dn !== 4'(1) << w || dd !== m_data[w]) begin
                miscompares++;
                $display("FAIL rstmid_xfer%0d: got done=%b data=%h want done=%b data=%h", i, dn, dd, 4'(1) << w, m_data[w]);
            end
        end
        vectors++; if (done_pulses - p0 != 2) begin miscompares++; $display("FAIL rstmid_pulses: got %0d want 2", done_pulses - p0); end
    endtask

    task automatic test_no_timeout();
        int n, drops; logic [7:0] d; logic [3:0] dn;
        d = 8'($urandom_range(0, 255));
        z_data = {8'h11, d, 8'h33, 8'h44};
        z_req = 4'b0100;
        n = 0;
        while (!z_xfer_req && n < 10) begin tick(); n++; end
        drops = 0;
        repeat (5000) begin
            tick();
            if (!z_xfer_req) drops++;
        end
        z_ack = 1'b1;
        n = 0;
        while (z_done == '0 && n < 10) begin tick(); n++; end
        dn = z_done;
        vectors++; if (dn !== 4'b0100 || z_xfer_data !== d) begin miscompares++; $display("FAIL nto_done: got done=%b data=%h want 0100 %h", dn, z_xfer_data, d); end
        z_req = '0;
        tick();
        tick();
        z_ack = 1'b0;
        n = 0;
        while (z_busy && n < 10) begin tick(); n++; end
        vectors++; if (drops != 0 || z_to_pulses != 0) begin miscompares++; $display("FAIL nto_timeout: got drops=%0d timeouts=%0d want 0 0", drops, z_to_pulses); end
        vectors++; if (z_done_pulses != 1 || z_busy !== 1'b0) begin miscompares++; $display("FAIL nto_pulses: got %0d busy=%b want 1 0", z_done_pulses, z_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_ptr_wrap();
        test_random_rr();
        test_drop_mid();
        test_timeout();
        test_reset_mid();
        test_no_timeout();
        vectors++; if (multi_hot != 0) begin miscompares++; $display("FAIL done_onehot: got %0d violations want 0", multi_hot); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
